// File: rtl/core_pkg.sv
// Shared types and opcode constants for the 9-bit-instruction core control path.
package core_pkg;

  // Opcode field IrOut[7:4] values that steer the sequencer
  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_ADDC  = 4'h7;
  localparam logic [3:0] OP_SUBC  = 4'h9;
  localparam logic [3:0] OP_BEQ   = 4'hA;
  localparam logic [3:0] OP_BTR   = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALTED
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_BRANCH, CLS_LOAD, CLS_STORE, CLS_HALT
  } instr_class_e;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Sequencer <-> ROM/datapath/data-memory signal bundle.
interface multicycle_sequencer_if #(parameter int CNT_W = 16);
  logic             Start;
  logic [8:0]       InstrIn;
  logic             ZeroFlag;
  logic             CondFlag;
  logic             MemAck;
  logic [8:0]       IrOut;
  logic [3:0]       AluOp;
  logic             AluCarryEn;
  logic             RegWrEn;
  logic             MemRdReq;
  logic             MemWrReq;
  logic             PcInc;
  logic             PcBranch;
  logic             Busy;
  logic             Done;
  logic             TimeoutErr;
  logic [CNT_W-1:0] InstrCount;

  // sequencer side
  modport master (
    input  Start, InstrIn, ZeroFlag, CondFlag, MemAck,
    output IrOut, AluOp, AluCarryEn, RegWrEn, MemRdReq, MemWrReq,
           PcInc, PcBranch, Busy, Done, TimeoutErr, InstrCount
  );

  // datapath / environment side
  modport slave (
    output Start, InstrIn, ZeroFlag, CondFlag, MemAck,
    input  IrOut, AluOp, AluCarryEn, RegWrEn, MemRdReq, MemWrReq,
           PcInc, PcBranch, Busy, Done, TimeoutErr, InstrCount
  );
endinterface

// File: rtl/instr_classify.sv
// Combinational decode of the latched instruction into its sequencing class.
module instr_classify
  import core_pkg::*;
(
  input  logic [8:0]   ir,
  output instr_class_e cls,
  output logic         carry_op,
  output logic         br_sel
);
  logic [3:0] op;
  logic       unused_lo;

  assign op        = ir[7:4];
  assign unused_lo = ^ir[3:0];

  // Immediate-class words (ir[8]=1) always run the ALU path, even with opcode 1111
  always_comb begin
    cls      = CLS_ALU;
    carry_op = (op == OP_ADDC) || (op == OP_SUBC);
    br_sel   = op[0];  // beq (1010) tests ZeroFlag, btr (1011) tests CondFlag
    if (!ir[8]) begin
      case (op)
        OP_LOAD:        cls = CLS_LOAD;
        OP_STORE:       cls = CLS_STORE;
        OP_BEQ, OP_BTR: cls = CLS_BRANCH;
        OP_HALT:        cls = CLS_HALT;
        default:        cls = CLS_ALU;
      endcase
    end
  end
endmodule

// File: rtl/multicycle_sequencer.sv
// FETCH/DECODE/EXEC/MEM/WB control sequencer with memory timeout and retire count.
module multicycle_sequencer
  import core_pkg::*;
#(
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_W       = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  multicycle_sequencer_if.master bus
);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  state_e       state;
  instr_class_e cls;
  logic [8:0]   ir;
  logic [TW-1:0] tcnt;
  logic         terr;
  logic [CNT_W-1:0] cnt;
  logic         carry_op, br_sel, taken;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  instr_classify u_cls (
    .ir       (ir),
    .cls      (cls),
    .carry_op (carry_op),
    .br_sel   (br_sel)
  );

  assign taken = br_sel ? bus.CondFlag : bus.ZeroFlag;

  // Control FSM: state, instruction register, memory timeout, error and retire count
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= ST_IDLE;
      ir    <= '0;
      tcnt  <= '0;
      terr  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (bus.Start) begin
            state <= ST_FETCH;
            terr  <= 1'b0;
            cnt   <= '0;
          end
        end
        ST_FETCH: begin
          ir    <= bus.InstrIn;
          state <= ST_DECODE;
        end
        ST_DECODE: begin
          tcnt <= '0;
          case (cls)
            CLS_HALT:             state <= ST_HALTED;
            CLS_LOAD, CLS_STORE:  state <= ST_MEM;
            default:              state <= ST_EXEC;
          endcase
        end
        ST_EXEC: begin
          if (cls == CLS_BRANCH) begin
            state <= ST_FETCH;
            cnt   <= sat_inc(cnt);
          end else begin
            state <= ST_WB;
          end
        end
        ST_MEM: begin
          // an ack arriving in the expiry cycle still completes the access
          if (bus.MemAck) begin
            if (cls == CLS_STORE) begin
              state <= ST_FETCH;
              cnt   <= sat_inc(cnt);
            end else begin
              state <= ST_WB;
            end
          end else if (tcnt == TW'(MEM_TIMEOUT - 1)) begin
            terr  <= 1'b1;
            state <= ST_HALTED;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_WB: begin
          state <= ST_FETCH;
          cnt   <= sat_inc(cnt);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Enables decode from registered state/IR plus EXEC flags and MemAck; InstrIn never reaches them
  assign bus.IrOut      = ir;
  assign bus.AluOp      = (state == ST_EXEC) ? ir[7:4] : 4'h0;
  assign bus.AluCarryEn = (state == ST_EXEC) && (cls == CLS_ALU) && carry_op;
  assign bus.RegWrEn    = (state == ST_WB);
  assign bus.MemRdReq   = (state == ST_MEM) && (cls == CLS_LOAD);
  assign bus.MemWrReq   = (state == ST_MEM) && (cls == CLS_STORE);
  assign bus.PcBranch   = (state == ST_EXEC) && (cls == CLS_BRANCH) && taken;
  assign bus.PcInc      = (state == ST_WB)
                       || ((state == ST_EXEC) && (cls == CLS_BRANCH) && !taken)
                       || ((state == ST_MEM) && (cls == CLS_STORE) && bus.MemAck);
  assign bus.Busy       = !((state == ST_IDLE) || (state == ST_HALTED));
  assign bus.Done       = (state == ST_HALTED);
  assign bus.TimeoutErr = terr;
  assign bus.InstrCount = cnt;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed + random bench for multicycle_sequencer against a per-instruction trace model.
module tb_multicycle_sequencer;
  localparam int T = 8;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  multicycle_sequencer_if #(.CNT_W(16)) bus ();
  multicycle_sequencer_if #(.CNT_W(3))  bus3 ();

  multicycle_sequencer #(.MEM_TIMEOUT(T), .CNT_W(16)) dut  (.Clk(Clk), .Reset(Reset), .bus(bus));
  multicycle_sequencer #(.MEM_TIMEOUT(T), .CNT_W(3))  dut3 (.Clk(Clk), .Reset(Reset), .bus(bus3));

  // narrow-counter copy sees identical stimulus
  assign bus3.Start    = bus.Start;
  assign bus3.InstrIn  = bus.InstrIn;
  assign bus3.ZeroFlag = bus.ZeroFlag;
  assign bus3.CondFlag = bus.CondFlag;
  assign bus3.MemAck   = bus.MemAck;

  logic [11:0] outv;
  assign outv = {bus.AluOp, bus.AluCarryEn, bus.RegWrEn, bus.MemRdReq, bus.MemWrReq,
                 bus.PcInc, bus.PcBranch, bus.Busy, bus.Done};

  int n_chk = 0, n_err = 0;
  logic [15:0] m_cnt;
  logic [2:0]  m_cnt3;
  logic        m_terr, m_halted;

  localparam int K_ALU = 0, K_BR = 1, K_LD = 2, K_ST = 3, K_HALT = 4;

  function automatic logic [11:0] mk(input logic [3:0] a, input logic c, rw, rd, wr, inc, br, busy, done);
    return {a, c, rw, rd, wr, inc, br, busy, done};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock: drive MemAck, compare outputs mid-cycle, step to just after the next edge
  task automatic cyc(input logic [11:0] exp, input logic ack, input string tag);
    bus.MemAck = ack;
    @(negedge Clk);
    chk(tag, 32'(outv), 32'(exp));
    @(posedge Clk); #1;
    bus.MemAck = 1'b0;
  endtask

  task automatic retire();
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
    if (m_cnt3 != 3'h7) m_cnt3 = m_cnt3 + 1;
  endtask

  task automatic start();
    bus.Start = 1'b1;
    cyc(m_halted ? mk(0,0,0,0,0,0,0,0,1) : 12'h000, 1'b0, "start");
    bus.Start = 1'b0;
    m_cnt = 0; m_cnt3 = 0; m_terr = 0; m_halted = 0;
    chk("start.cnt", 32'(bus.InstrCount), 32'(m_cnt));
    chk("start.terr", 32'(bus.TimeoutErr), 32'(m_terr));
  endtask

  // ack_at: MEM cycle (1..T) carrying MemAck, 0 = never acknowledged
  task automatic run_instr(input logic [8:0] ins, input logic zf, input logic cf,
                           input int ack_at, input string tag);
    logic [3:0] op;
    int kind;
    logic tk, got_ack;
    op = ins[7:4];
    if (ins[8]) kind = K_ALU;
    else if (op == 4'h0) kind = K_LD;
    else if (op == 4'h3) kind = K_ST;
    else if (op == 4'hA || op == 4'hB) kind = K_BR;
    else if (op == 4'hF) kind = K_HALT;
    else kind = K_ALU;

    bus.InstrIn = ins; bus.ZeroFlag = zf; bus.CondFlag = cf;
    cyc(mk(0,0,0,0,0,0,0,1,0), 1'b0, $sformatf("%s.fetch", tag));
    bus.InstrIn = 9'($urandom);
    chk($sformatf("%s.ir", tag), 32'(bus.IrOut), 32'(ins));
    cyc(mk(0,0,0,0,0,0,0,1,0), 1'b0, $sformatf("%s.decode", tag));

    case (kind)
      K_HALT: m_halted = 1;
      K_ALU: begin
        cyc(mk(op, (op == 4'h7 || op == 4'h9), 0,0,0,0,0,1,0), 1'b0, $sformatf("%s.exec", tag));
        cyc(mk(0,0,1,0,0,1,0,1,0), 1'b0, $sformatf("%s.wb", tag));
        retire();
      end
      K_BR: begin
        tk = (op == 4'hA) ? zf : cf;
        cyc(mk(op,0,0,0,0,!tk,tk,1,0), 1'b0, $sformatf("%s.exec", tag));
        retire();
      end
      default: begin
        got_ack = 0;
        for (int m = 1; m <= T; m++) begin
          got_ack = (m == ack_at);
          cyc(mk(0,0,0,kind == K_LD,kind == K_ST,(kind == K_ST) && got_ack,0,1,0), got_ack,
              $sformatf("%s.mem%0d", tag, m));
          if (got_ack) break;
        end
        if (!got_ack) begin
          m_terr = 1; m_halted = 1;
        end else begin
          if (kind == K_LD) cyc(mk(0,0,1,0,0,1,0,1,0), 1'b0, $sformatf("%s.wb", tag));
          retire();
        end
      end
    endcase

    if (m_halted) chk($sformatf("%s.halted", tag), 32'(outv), 32'(mk(0,0,0,0,0,0,0,0,1)));
    chk($sformatf("%s.cnt", tag), 32'(bus.InstrCount), 32'(m_cnt));
    chk($sformatf("%s.cnt3", tag), 32'(bus3.InstrCount), 32'(m_cnt3));
    chk($sformatf("%s.terr", tag), 32'(bus.TimeoutErr), 32'(m_terr));
  endtask

  initial begin
    Reset = 1'b0;
    bus.Start = 0; bus.InstrIn = 0; bus.ZeroFlag = 0; bus.CondFlag = 0; bus.MemAck = 0;
    m_cnt = 0; m_cnt3 = 0; m_terr = 0; m_halted = 0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst.out", 32'(outv), 32'h0);
    chk("rst.ir", 32'(bus.IrOut), 32'h0);
    chk("rst.cnt", 32'(bus.InstrCount), 32'h0);
    chk("rst.terr", 32'(bus.TimeoutErr), 32'h0);
    Reset = 1'b1;
    @(posedge Clk); #1;
    chk("idle.out", 32'(outv), 32'h0);
    start();

    // main classes
    run_instr(9'h060, 0, 0, 0, "add");
    run_instr(9'h0A0, 1, 0, 0, "beq_t");
    run_instr(9'h0A0, 0, 1, 0, "beq_nt");
    run_instr(9'h0B0, 0, 1, 0, "btr_t");
    run_instr(9'h0B0, 1, 0, 0, "btr_nt");
    run_instr(9'h070, 0, 0, 0, "addc");
    run_instr(9'h090, 0, 0, 0, "subc");
    run_instr(9'h1F5, 0, 0, 0, "imm_f");
    run_instr(9'h000, 0, 0, 3, "load3");
    run_instr(9'h030, 0, 0, 1, "store1");

    // timeout boundary: no ack halts with error, ack on the last cycle does not
    run_instr(9'h030, 0, 0, 0, "store_to");
    start();
    run_instr(9'h030, 0, 0, T, "store_last");
    run_instr(9'h000, 0, 0, 0, "load_to");
    start();

    // halt then restart; Start while busy is ignored
    run_instr(9'h060, 0, 0, 0, "pre_halt");
    run_instr(9'h0F0, 0, 0, 0, "halt");
    start();
    bus.Start = 1'b1;
    run_instr(9'h020, 0, 0, 0, "busy_start");
    bus.Start = 1'b0;

    // saturation of the narrow counter
    for (int i = 0; i < 9; i++) run_instr(9'h040, 0, 0, 0, "sat");

    // async reset in the middle of a memory wait
    bus.InstrIn = 9'h000;
    cyc(mk(0,0,0,0,0,0,0,1,0), 1'b0, "rstmem.fetch");
    cyc(mk(0,0,0,0,0,0,0,1,0), 1'b0, "rstmem.decode");
    cyc(mk(0,0,0,1,0,0,0,1,0), 1'b0, "rstmem.mem1");
    #2 Reset = 1'b0;
    #1;
    chk("rstmem.out", 32'(outv), 32'h0);
    chk("rstmem.ir", 32'(bus.IrOut), 32'h0);
    chk("rstmem.cnt", 32'(bus.InstrCount), 32'h0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    m_cnt = 0; m_cnt3 = 0; m_terr = 0; m_halted = 0;
    @(posedge Clk); #1;
    chk("rstmem.quiet", 32'(outv), 32'h0);
    start();

    // random program
    for (int i = 0; i < 60; i++) begin
      logic [8:0] ins;
      ins = 9'($urandom);
      run_instr(ins, 1'($urandom), 1'($urandom), int'($urandom_range(0, T)), "rnd");
      if (m_halted) start();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control sequencer for the 9-bit-instruction core.
- Latches the instruction word from the instruction ROM and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Issues single-cycle enables to the program counter, ALU, register file and data memory.
- Sits between the instruction ROM/fetch unit and the datapath, and handles data-memory handshaking, halt and run statistics.

Parameters:
- MEM_TIMEOUT, 8, max cycles MemRdReq/MemWrReq may wait for MemAck before TimeoutErr.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  begin execution from IDLE or HALTED (level, sampled on edge).
- InstrIn  in  9  instruction word from instruction ROM at current PC (combinational).
- ZeroFlag  in  1  ALU zero flag, valid during EXEC.
- CondFlag  in  1  condition-register bit, valid during EXEC.
- MemAck  in  1  data memory completion, one-cycle pulse.
- IrOut  out  9  latched instruction register.
- AluOp  out  4  equals IrOut[7:4] in EXEC, else 0.
- AluCarryEn  out  1  carry flag update enable (add carry/sub carry), EXEC only.
- RegWrEn  out  1  register-file write, WB only.
- MemRdReq  out  1  data memory read request.
- MemWrReq  out  1  data memory write request.
- PcInc  out  1  PC+1 pulse.
- PcBranch  out  1  PC load-branch-target pulse.
- Busy  out  1  state not IDLE/HALTED.
- Done  out  1  high in HALTED.
- TimeoutErr  out  1  sticky memory-timeout error.
- InstrCount  out  CNT_W  retired-instruction count, saturating.

Behaviour:
- Reset (async, Reset=0): state IDLE, IrOut=0, InstrCount=0, TimeoutErr=0, all enables/requests 0, Busy=0, Done=0. Asserting reset mid-instruction aborts the instruction; no pulse is emitted afterwards.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED.
- IDLE/HALTED:
  - Start=1 -> FETCH.
  - Start clears TimeoutErr and InstrCount.
  - Start while Busy is ignored.
- FETCH: IrOut <= InstrIn; -> DECODE.
- DECODE: classifies IrOut. The class decides the path from DECODE:
  - Opcode 1111 (halt): -> HALTED. No PC pulse. Not counted.
  - Opcode 0000 (load): -> MEM with MemRdReq.
  - Opcode 0011 (store): -> MEM with MemWrReq.
  - All other codes: -> EXEC.
- Opcode classes handled in EXEC/WB (IrOut[8]=0):
  - ALU/move: 0001, 0010, 0100-1001, 1100-1110.
  - Branch: 1010 (beq), 1011 (btr).
- IrOut[8]=1 (immediate class): handled as ALU/move with AluOp=IrOut[7:4].
- EXEC:
  - ALU/move: AluOp driven, AluCarryEn=1 for 0111/1001; -> WB.
  - beq: PcBranch=1 if ZeroFlag, else PcInc=1; retire; -> FETCH.
  - btr: same, using CondFlag.
- MEM:
  - Request held high until the cycle MemAck=1.
  - load -> WB.
  - store: PcInc=1 in the ack cycle, retire, -> FETCH.
  - Timeout counter increments each MEM cycle without ack. Reaching MEM_TIMEOUT sets TimeoutErr, drops the request, and -> HALTED without retiring.
  - MemAck in the same cycle as expiry: ack wins, no error.
- WB: RegWrEn=1, PcInc=1, retire; -> FETCH.
- Exactly one of PcInc/PcBranch per retired instruction; never both.
- Retire means InstrCount+1, saturating at all-ones.
- Latency:
  - ALU/move: 4 cycles.
  - Branch: 3 cycles.
  - Load: 3 + ack wait.
  - Store: 2 + ack wait (1 wait cycle minimum).
- All outputs registered or decoded from state+IrOut only; no combinational path from InstrIn to enables.

Decomposition:
- Shared package core_pkg:
  - Opcode constants OP_LOAD..OP_HALT (4-bit).
  - State enum.
  - Instruction class enum (ALU, BRANCH, LOAD, STORE, HALT).
- One sub-module, instr_classify: purely combinational, IrOut -> class, carry-op and branch-select bits. The FSM, timeout counter and InstrCount stay in multicycle_sequencer.

Test Plan:
- Reset then Start with InstrIn=9'h060 (add) -> FETCH,DECODE,EXEC,WB. AluOp=4'h6 in EXEC. RegWrEn and PcInc high in WB cycle 4. InstrCount=1.
- beq 9'h0A0 with ZeroFlag=1 -> PcBranch at cycle 3, no RegWrEn. Repeat with ZeroFlag=0 -> PcInc instead.
- load 9'h000, MemAck after 3 cycles -> MemRdReq high exactly until ack, then WB with RegWrEn and PcInc.
- store 9'h030, no ack, MEM_TIMEOUT=8 -> request drops after 8 MEM cycles. TimeoutErr=1, Done=1, InstrCount unchanged. Ack exactly on the 8th cycle -> no error.
- halt 9'h0F0 -> HALTED, Done=1, no PC pulse. Start pulse -> FETCH, InstrCount reset to 0.
- Reset asserted mid-MEM -> all outputs 0 immediately (async). Force InstrCount to 16'hFFFF, retire one more -> stays 16'hFFFF.
